// File: rtl/branch_redirect_controller.sv
// Branch redirect controller: after a taken branch resolves in EX, it issues a
// one-shot fetch redirect and squashes the IF/OF and OF/EX latches for
// FLUSH_DEPTH unstalled cycles. It also keeps saturating counts of branches and
// taken branches.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), synchronous active-low reset
//   i_ex_valid               EX holds a real instruction
//   i_ex_is_branch           EX instruction is a branch/call/ret
//   i_ex_branch_taken        branch unit taken decision
//   i_ex_branch_pc           resolved branch target
//   i_pipe_stall             global pipeline freeze
//   i_clear_stats            synchronous clear of both counters
//   o_pc_redirect_valid      fetch loads o_pc_redirect_target this cycle
//   o_pc_redirect_target     latched branch target
//   o_flush_if_of            squash the IF/OF latch
//   o_flush_of_ex            squash the OF/EX latch
//   o_busy                   redirect or squash window in progress
//   o_branch_count           accepted branches (saturating)
//   o_taken_count            accepted taken branches (saturating)
module branch_redirect_controller #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ex_valid,
    input  logic              i_ex_is_branch,
    input  logic              i_ex_branch_taken,
    input  logic [ADDR_W-1:0] i_ex_branch_pc,
    input  logic              i_pipe_stall,
    input  logic              i_clear_stats,
    output logic              o_pc_redirect_valid,
    output logic [ADDR_W-1:0] o_pc_redirect_target,
    output logic              o_flush_if_of,
    output logic              o_flush_of_ex,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_branch_count,
    output logic [CNT_W-1:0]  o_taken_count
);

    // Holds FLUSH_DEPTH-1, the number of squash cycles after the redirect cycle
    localparam int unsigned      SQ_W    = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [SQ_W-1:0]  SQ_INIT = SQ_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SQ_W-1:0]   r_sq_cnt;
    logic [SQ_W-1:0]   w_sq_cnt_nxt;
    logic              w_latch_target;
    logic              w_accept;
    logic              r_redirect;
    logic              r_flush;
    logic              r_busy;
    logic [ADDR_W-1:0] r_target;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    // Branches are only considered when the window is closed; anything seen
    // during the window is wrong-path.
    assign w_accept = i_ex_valid & i_ex_is_branch & ~i_pipe_stall & (r_state == ST_IDLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_sq_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sq_cnt <= w_sq_cnt_nxt;
        end
    end

    // Next-state logic; stalls freeze the window in place
    always_comb begin
        w_state_nxt    = r_state;
        w_sq_cnt_nxt   = r_sq_cnt;
        w_latch_target = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && i_ex_branch_taken) begin
                    w_state_nxt    = ST_REDIRECT;
                    w_latch_target = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (!i_pipe_stall) begin
                    if (FLUSH_DEPTH <= 1) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt  = ST_SQUASH;
                        w_sq_cnt_nxt = SQ_INIT;
                    end
                end
            end
            ST_SQUASH: begin
                if (!i_pipe_stall) begin
                    w_sq_cnt_nxt = r_sq_cnt - SQ_W'(1);
                    if (r_sq_cnt <= SQ_W'(1)) begin
                        w_state_nxt  = ST_IDLE;
                        w_sq_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_sq_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs registered from the next state so they line up with r_state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            r_busy     <= 1'b0;
            r_target   <= '0;
        end else begin
            r_redirect <= (w_state_nxt == ST_REDIRECT);
            r_flush    <= (w_state_nxt != ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_latch_target) begin
                r_target <= i_ex_branch_pc;
            end
        end
    end

    // Saturating statistics; clear beats a same-cycle increment
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear_stats) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (w_accept) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (i_ex_branch_taken && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pc_redirect_valid  = r_redirect;
    assign o_pc_redirect_target = r_target;
    assign o_flush_if_of        = r_flush;
    assign o_flush_of_ex        = r_flush;
    assign o_busy               = r_busy;
    assign o_branch_count       = r_branch_cnt;
    assign o_taken_count        = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Bench for branch_redirect_controller. Two instances share the stimulus:
// u_dut (FLUSH_DEPTH=2, CNT_W=16) and u_dut4 (FLUSH_DEPTH=1, CNT_W=4). Each
// instance is compared every cycle against a window-countdown reference model.
module tb_branch_redirect_controller;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic        stall;
    logic        clr;

    logic        redir_a, fif_a, fex_a, busy_a;
    logic [31:0] tgt_a;
    logic [15:0] bc_a, tc_a;
    logic        redir_b, fif_b, fex_b, busy_b;
    logic [31:0] tgt_b;
    logic [3:0]  bc_b, tc_b;

    int checks   = 0;
    int failures = 0;

    // Reference model, per instance: rem = flush cycles left including the current one
    int          m_depth [2] = '{2, 1};
    int          m_max   [2] = '{65535, 15};
    int          m_rem   [2];
    bit          m_redir [2];
    logic [31:0] m_tgt   [2];
    int          m_bc    [2];
    int          m_tc    [2];

    branch_redirect_controller #(.ADDR_W(32), .FLUSH_DEPTH(2), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch),
        .i_ex_branch_taken(ex_taken), .i_ex_branch_pc(ex_pc), .i_pipe_stall(stall),
        .i_clear_stats(clr), .o_pc_redirect_valid(redir_a), .o_pc_redirect_target(tgt_a),
        .o_flush_if_of(fif_a), .o_flush_of_ex(fex_a), .o_busy(busy_a),
        .o_branch_count(bc_a), .o_taken_count(tc_a)
    );

    branch_redirect_controller #(.ADDR_W(32), .FLUSH_DEPTH(1), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch),
        .i_ex_branch_taken(ex_taken), .i_ex_branch_pc(ex_pc), .i_pipe_stall(stall),
        .i_clear_stats(clr), .o_pc_redirect_valid(redir_b), .o_pc_redirect_target(tgt_b),
        .o_flush_if_of(fif_b), .o_flush_of_ex(fex_b), .o_busy(busy_b),
        .o_branch_count(bc_b), .o_taken_count(tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            acc = ex_valid && ex_is_branch && !stall && (m_rem[k] == 0);
            if (!rst_n) begin
                m_rem[k] = 0; m_redir[k] = 0; m_tgt[k] = '0; m_bc[k] = 0; m_tc[k] = 0;
            end else begin
                if (m_rem[k] == 0) begin
                    if (acc && ex_taken) begin
                        m_rem[k] = m_depth[k]; m_redir[k] = 1; m_tgt[k] = ex_pc;
                    end
                end else if (!stall) begin
                    m_rem[k]--; m_redir[k] = 0;
                end
                if (clr) begin
                    m_bc[k] = 0; m_tc[k] = 0;
                end else if (acc) begin
                    if (m_bc[k] < m_max[k]) m_bc[k]++;
                    if (ex_taken && m_tc[k] < m_max[k]) m_tc[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_redirect", 64'(redir_a), 64'(m_redir[0]));
        chk("a_target",   64'(tgt_a),   64'(m_tgt[0]));
        chk("a_flush_if", 64'(fif_a),   64'(m_rem[0] > 0));
        chk("a_flush_ex", 64'(fex_a),   64'(m_rem[0] > 0));
        chk("a_busy",     64'(busy_a),  64'(m_rem[0] > 0));
        chk("a_bcount",   64'(bc_a),    64'(m_bc[0]));
        chk("a_tcount",   64'(tc_a),    64'(m_tc[0]));
        chk("b_redirect", 64'(redir_b), 64'(m_redir[1]));
        chk("b_target",   64'(tgt_b),   64'(m_tgt[1]));
        chk("b_flush_if", 64'(fif_b),   64'(m_rem[1] > 0));
        chk("b_flush_ex", 64'(fex_b),   64'(m_rem[1] > 0));
        chk("b_busy",     64'(busy_b),  64'(m_rem[1] > 0));
        chk("b_bcount",   64'(bc_b),    64'(m_bc[1]));
        chk("b_tcount",   64'(tc_b),    64'(m_tc[1]));
    endtask

    // Drive inputs, take one edge, then sample at the falling edge
    task automatic step(input logic rn, input logic v, input logic br, input logic tk,
                        input logic [31:0] pc, input logic st, input logic cl);
        rst_n = rn; ex_valid = v; ex_is_branch = br; ex_taken = tk;
        ex_pc = pc; stall = st; clr = cl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_redir[k] = 0; m_tgt[k] = '0; m_bc[k] = 0; m_tc[k] = 0;
        end
        rst_n = 0; ex_valid = 0; ex_is_branch = 0; ex_taken = 0;
        ex_pc = '0; stall = 0; clr = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);

        // Reset asserted mid-squash abandons the window
        step(1, 1, 1, 1, 32'h0000_0100, 0, 0);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        chk("reset_busy",   64'(busy_a), 64'(0));
        chk("reset_bcount", 64'(bc_a),   64'(0));
        idle(1);

        // Taken beq to 0x40: redirect T+1, flushes T+1..T+2, idle at T+3
        step(1, 1, 1, 1, 32'h0000_0040, 0, 0);
        chk("beq_redirect_T1", 64'(redir_a), 64'(1));
        chk("beq_target_T1",   64'(tgt_a),   64'h40);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        chk("beq_flush_T2", 64'(fif_a), 64'(1));
        chk("beq_redir_T2", 64'(redir_a), 64'(0));
        step(1, 0, 0, 0, 32'h0, 0, 0);
        chk("beq_idle_T3", 64'(busy_a), 64'(0));
        chk("beq_bcount",  64'(bc_a), 64'(1));
        chk("beq_tcount",  64'(tc_a), 64'(1));

        // Not-taken bgt after a stats clear
        step(1, 0, 0, 0, 32'h0, 0, 1);
        step(1, 1, 1, 0, 32'h0000_0080, 0, 0);
        chk("bgt_no_redirect", 64'(redir_a), 64'(0));
        chk("bgt_bcount", 64'(bc_a), 64'(1));
        chk("bgt_tcount", 64'(tc_a), 64'(0));
        idle(2);

        // Taken ret to 0x1234 with 3 stall cycles right after T
        step(1, 1, 1, 1, 32'h0000_1234, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0, 1, 0);
        chk("ret_redirect_held", 64'(redir_a), 64'(1));
        step(1, 0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 32'h0, 1, 0);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        idle(1);

        // Second taken branch presented while squashing is wrong-path
        step(1, 1, 1, 1, 32'h0000_2000, 0, 0);
        step(1, 1, 1, 1, 32'h0000_3000, 0, 0);
        chk("wrongpath_target", 64'(tgt_a), 64'h2000);
        idle(3);

        // Saturate the 4-bit counters, then clear alongside an accept
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, 1, 32'h0000_0400 + 32'(i), 0, 0);
            idle(2);
        end
        chk("sat_bcount4", 64'(bc_b), 64'(15));
        chk("sat_tcount4", 64'(tc_b), 64'(15));
        step(1, 1, 1, 1, 32'h0000_0500, 0, 1);
        chk("clear_bcount4", 64'(bc_b), 64'(0));
        chk("clear_tcount4", 64'(tc_b), 64'(0));
        idle(3);

        // Randomized traffic including stalls, clears and occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic rn, v, br, tk, st, cl;
            rn = ($urandom_range(0, 99) != 0);
            v  = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 3) != 0);
            tk = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 49) == 0);
            step(rn, v, br, tk, 32'($urandom), st, cl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
